dso_trig_capture: RTL and testbench



---
 rtl/dso_pkg.sv | 23 ++
 rtl/dso_trig_detect.sv | 42 ++++
 rtl/dso_trig_capture.sv | 137 +++++++++++++
 tb/tb_dso_trig_capture.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/dso_pkg.sv
// Shared definitions for the DSO trigger/capture path.
//   dso_state_t : capture FSM states
//   TRIG_*      : trig_edge encodings
//   MODE_*      : trig_mode encodings
//   DSO_DATA_W  : default ADC sample width
package dso_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE_FILL,
        WAIT_TRIG,
        POST_FILL,
        DONE
    } dso_state_t;

    localparam logic TRIG_RISE   = 1'b0;
    localparam logic TRIG_FALL   = 1'b1;
    localparam logic MODE_AUTO   = 1'b0;
    localparam logic MODE_NORMAL = 1'b1;

    localparam int DSO_DATA_W = 8;

endpackage

// File: rtl/dso_trig_detect.sv
// Two-stage sample pipeline and level-crossing compare.
//   ad_clk, sys_rst : clock, async active-high reset
//   ad_data         : raw ADC sample
//   trig_level      : threshold (unsigned)
//   trig_edge       : TRIG_RISE / TRIG_FALL
//   d1              : sample delayed by one cycle (the sample being written)
//   trig_hit        : crossing between d2 and d1 this cycle
import dso_pkg::*;

module dso_trig_detect #(
    parameter int DATA_W = DSO_DATA_W
) (
    input  logic              ad_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] ad_data,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_edge,
    output logic [DATA_W-1:0] d1,
    output logic              trig_hit
);

    logic [DATA_W-1:0] d2;

    always_ff @(posedge ad_clk or posedge sys_rst) begin
        if (sys_rst) begin
            d1 <= '0;
            d2 <= '0;
        end else begin
            d1 <= ad_data;
            d2 <= d1;
        end
    end

    // Level is compared live, so a new threshold applies on the next compare.
    always_comb begin
        if (trig_edge == TRIG_FALL)
            trig_hit = (d2 > trig_level) && (d1 <= trig_level);
        else
            trig_hit = (d2 < trig_level) && (d1 >= trig_level);
    end

endmodule

// File: rtl/dso_trig_capture.sv
// Circular-buffer capture with level trigger and auto-mode timeout.
//   ad_clk, sys_rst           : clock, async active-high reset
//   ad_data                   : raw ADC sample
//   trig_level/edge/mode      : trigger setup
//   arm                       : start/restart pulse (aborts any frame in flight)
//   wr_en/wr_addr/wr_data     : waveform RAM write port
//   busy                      : PRE_FILL, WAIT_TRIG or POST_FILL
//   capture_done              : frame complete (DONE)
//   start_addr                : oldest sample of the completed frame
//   trig_auto                 : last trigger was forced by timeout
import dso_pkg::*;

module dso_trig_capture #(
    parameter int DATA_W    = DSO_DATA_W,
    parameter int ADDR_W    = 10,
    parameter int PRE_DEPTH = 512,
    parameter int AUTO_TO   = 1000000
) (
    input  logic              ad_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] ad_data,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_edge,
    input  logic              trig_mode,
    input  logic              arm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              capture_done,
    output logic [ADDR_W-1:0] start_addr,
    output logic              trig_auto
);

    localparam int DEPTH    = 2 ** ADDR_W;
    localparam int POST_LEN = DEPTH - PRE_DEPTH - 1;
    localparam int TW       = (AUTO_TO > 1) ? $clog2(AUTO_TO) : 1;

    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_DEPTH - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'((POST_LEN > 0) ? POST_LEN - 1 : 0);
    localparam logic [ADDR_W-1:0] PRE_OFF   = ADDR_W'(PRE_DEPTH);
    localparam logic [TW-1:0]     TO_LAST   = TW'(AUTO_TO - 1);

    dso_state_t        state, state_nxt;
    logic [ADDR_W-1:0] addr_nxt, cnt, cnt_nxt, trig_addr, trig_addr_nxt, start_nxt;
    logic [TW-1:0]     tcnt, tcnt_nxt;
    logic              auto_nxt, trig_hit, timeout;

    dso_trig_detect #(.DATA_W(DATA_W)) u_det (
        .ad_clk     (ad_clk),
        .sys_rst    (sys_rst),
        .ad_data    (ad_data),
        .trig_level (trig_level),
        .trig_edge  (trig_edge),
        .d1         (wr_data),
        .trig_hit   (trig_hit)
    );

    assign busy         = (state == PRE_FILL) || (state == WAIT_TRIG) || (state == POST_FILL);
    assign wr_en        = busy;
    assign capture_done = (state == DONE);
    assign timeout      = (trig_mode == MODE_AUTO) && (tcnt == TO_LAST);

    always_comb begin
        state_nxt     = state;
        addr_nxt      = wr_en ? wr_addr + 1'b1 : wr_addr;
        cnt_nxt       = cnt;
        tcnt_nxt      = tcnt;
        trig_addr_nxt = trig_addr;
        start_nxt     = start_addr;
        auto_nxt      = trig_auto;

        if (arm) begin
            // Same entry from any state; an in-flight frame is simply dropped.
            state_nxt = PRE_FILL;
            addr_nxt  = '0;
            cnt_nxt   = '0;
            auto_nxt  = 1'b0;
        end else begin
            case (state)
                PRE_FILL: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == PRE_LAST) begin
                        state_nxt = WAIT_TRIG;
                        tcnt_nxt  = '0;
                    end
                end
                WAIT_TRIG: begin
                    // Saturate so a late switch to auto mode fires at once
                    // instead of after a counter wrap.
                    if (tcnt != TO_LAST)
                        tcnt_nxt = tcnt + 1'b1;
                    if (trig_hit || timeout) begin
                        trig_addr_nxt = wr_addr;
                        auto_nxt      = !trig_hit;
                        cnt_nxt       = '0;
                        if (POST_LEN == 0) begin
                            state_nxt = DONE;
                            start_nxt = wr_addr - PRE_OFF;
                        end else begin
                            state_nxt = POST_FILL;
                        end
                    end
                end
                POST_FILL: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == POST_LAST) begin
                        state_nxt = DONE;
                        start_nxt = trig_addr - PRE_OFF;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ad_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            wr_addr    <= '0;
            cnt        <= '0;
            tcnt       <= '0;
            trig_addr  <= '0;
            start_addr <= '0;
            trig_auto  <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_addr    <= addr_nxt;
            cnt        <= cnt_nxt;
            tcnt       <= tcnt_nxt;
            trig_addr  <= trig_addr_nxt;
            start_addr <= start_nxt;
            trig_auto  <= auto_nxt;
        end
    end

endmodule

// File: tb/tb_dso_trig_capture.sv
// Directed bench for dso_trig_capture (ADDR_W=4, PRE_DEPTH=4, AUTO_TO=32).
module tb_dso_trig_capture;

    logic       ad_clk = 1'b0;
    logic       sys_rst;
    logic [7:0] ad_data, trig_level;
    logic       trig_edge, trig_mode, arm;
    logic       wr_en, busy, capture_done, trig_auto;
    logic [3:0] wr_addr, start_addr;
    logic [7:0] wr_data;

    logic [7:0] mem [16];
    int nchk = 0;
    int nerr = 0;
    int n;

    dso_trig_capture #(.DATA_W(8), .ADDR_W(4), .PRE_DEPTH(4), .AUTO_TO(32)) dut (
        .ad_clk       (ad_clk),
        .sys_rst      (sys_rst),
        .ad_data      (ad_data),
        .trig_level   (trig_level),
        .trig_edge    (trig_edge),
        .trig_mode    (trig_mode),
        .arm          (arm),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .capture_done (capture_done),
        .start_addr   (start_addr),
        .trig_auto    (trig_auto)
    );

    always #5 ad_clk = ~ad_clk;

    // Waveform RAM model fed by the write port.
    always @(posedge ad_clk) if (wr_en) mem[wr_addr] <= wr_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ad_clk);
        #1;
    endtask

    // Sample k of stimulus pattern tno (k = 0 is presented on the arm edge).
    function automatic logic [7:0] val(input int tno, input int k);
        case (tno)
            0:       return 8'(k);
            1:       return (k == 1 || k >= 10) ? 8'd10 : 8'd200;
            default: return 8'd50;
        endcase
    endfunction

    // Arm, then stream the pattern until capture_done or lim cycles.
    task automatic cap(input int tno, input int lim, output int cyc);
        ad_data = val(tno, 0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("arm_addr0", wr_addr, 0);
        chk("arm_busy", busy, 1);
        cyc = 0;
        while (!capture_done && cyc < lim) begin
            ad_data = val(tno, cyc + 1);
            tick();
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst = 1'b1; arm = 1'b0; ad_data = '0;
        trig_level = 8'd20; trig_edge = 1'b0; trig_mode = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_done", capture_done, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_start", start_addr, 0);
        chk("rst_auto", trig_auto, 0);
        chk("rst_data", wr_data, 0);
        sys_rst = 1'b0;

        // Idle with no arm
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("idle_wr_en", wr_en, 0);
            chk("idle_busy", busy, 0);
            chk("idle_done", capture_done, 0);
        end

        // Rising ramp, trigger at sample 20 (addr 4)
        cap(0, 100, n);
        chk("ramp_cycles", n, 32);
        chk("ramp_start", start_addr, 0);
        chk("ramp_auto", trig_auto, 0);
        chk("ramp_busy", busy, 0);
        chk("ramp_wr_en", wr_en, 0);
        for (int i = 0; i < 16; i++) chk("ramp_ram", mem[i], 16 + i);

        // Falling edge; crossing at sample 1 falls in PRE_FILL and is ignored
        trig_level = 8'd100; trig_edge = 1'b1; trig_mode = 1'b1;
        cap(1, 100, n);
        chk("fall_cycles", n, 22);
        chk("fall_start", start_addr, 6);
        chk("fall_auto", trig_auto, 0);
        repeat (5) tick();
        chk("fall_hold_done", capture_done, 1);
        chk("fall_hold_start", start_addr, 6);

        // Auto mode timeout: trigger at addr 3 (sample 35)
        trig_edge = 1'b0; trig_mode = 1'b0;
        cap(2, 100, n);
        chk("auto_cycles", n, 47);
        chk("auto_start", start_addr, 15);
        chk("auto_flag", trig_auto, 1);

        // Normal mode, no crossing: waits and wraps
        trig_mode = 1'b1;
        cap(2, 1000, n);
        chk("norm_cycles", n, 1000);
        chk("norm_done", capture_done, 0);
        chk("norm_busy", busy, 1);
        chk("norm_addr", wr_addr, 8);
        chk("norm_start_kept", start_addr, 15);

        // Async reset mid-WAIT_TRIG
        sys_rst = 1'b1;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_wr_en", wr_en, 0);
        chk("mrst_addr", wr_addr, 0);
        chk("mrst_start", start_addr, 0);
        chk("mrst_data", wr_data, 0);
        tick();
        sys_rst = 1'b0;
        tick();
        chk("mrst_idle_busy", busy, 0);
        chk("mrst_idle_done", capture_done, 0);

        // Arm during POST_FILL aborts the frame and restarts
        trig_level = 8'd20; trig_edge = 1'b0;
        cap(0, 25, n);
        chk("abort_pre_done", capture_done, 0);
        chk("abort_pre_busy", busy, 1);
        cap(0, 100, n);
        chk("abort_cycles", n, 32);
        chk("abort_start", start_addr, 0);
        chk("abort_auto", trig_auto, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
